// File: rtl/reg_file_sb_pkg.sv
// Shared constants and HI/LO move-select encodings for the register file slice.
package reg_file_sb_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 5;

   typedef enum logic [1:0] {
      MF_NONE = 2'b00,
      MF_LO   = 2'b01,
      MF_HI   = 2'b10,
      MF_RSVD = 2'b11
   } mf_sel_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: per-GPR and HI/LO pending bits plus read/move hazard detection.
module reg_scoreboard
   import reg_file_sb_pkg::*;
#(
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned NREAD    = 2,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NREAD*ADDR_W-1:0] raddr_i,
   input  logic                    we_i,
   input  logic [ADDR_W-1:0]       waddr_i,
   input  logic                    mv_req_i,
   input  logic [ADDR_W-1:0]       mf_addr_i,
   input  logic                    issue_i,
   input  logic [ADDR_W-1:0]       issue_addr_i,
   input  logic                    issue_hilo_i,
   input  logic                    hilo_we_i,
   output logic [NREAD:0]          stall_o,
   output logic                    mv_go_o
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DEPTH-1:0]  pend_q, pend_d;
   logic              hilo_pend_q, hilo_pend_d;
   logic              mv_stall;
   logic [ADDR_W-1:0] ra;

   always_comb begin
      mv_stall = mv_req_i && hilo_pend_q && !hilo_we_i;
      mv_go_o  = mv_req_i && !mv_stall;

      // Clears first so a same-cycle issue to the same register leaves it pending
      pend_d = pend_q;
      if (we_i)    pend_d[waddr_i]   = 1'b0;
      if (mv_go_o) pend_d[mf_addr_i] = 1'b0;
      if (issue_i && !((ZERO_REG != 0) && (issue_addr_i == '0)))
         pend_d[issue_addr_i] = 1'b1;

      hilo_pend_d = issue_hilo_i || (hilo_pend_q && !hilo_we_i);

      stall_o = '0;
      ra      = '0;
      for (int unsigned k = 0; k < NREAD; k++) begin
         ra = raddr_i[k*ADDR_W +: ADDR_W];
         stall_o[k] = pend_q[ra]
                   && !(we_i && (waddr_i == ra))
                   && !(mv_go_o && (mf_addr_i == ra))
                   && !((ZERO_REG != 0) && (ra == '0));
      end
      stall_o[NREAD] = mv_stall;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         pend_q      <= '0;
         hilo_pend_q <= 1'b0;
      end else begin
         pend_q      <= pend_d;
         hilo_pend_q <= hilo_pend_d;
      end
   end

endmodule

// File: rtl/reg_file_sb.sv
// GPR file with HI/LO pair, move-from-HI/LO path, write-through bypass and hazard scoreboard.
module reg_file_sb
   import reg_file_sb_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned NREAD    = 2,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NREAD*ADDR_W-1:0] raddr_i,
   output logic [NREAD*DATA_W-1:0] rdata_o,
   input  logic                    we_i,
   input  logic [ADDR_W-1:0]       waddr_i,
   input  logic [DATA_W-1:0]       wdata_i,
   input  logic                    hilo_we_i,
   input  logic [2*DATA_W-1:0]     hilo_wdata_i,
   input  logic [1:0]              mf_sel_i,
   input  logic [ADDR_W-1:0]       mf_addr_i,
   input  logic                    issue_i,
   input  logic [ADDR_W-1:0]       issue_addr_i,
   input  logic                    issue_hilo_i,
   output logic [NREAD:0]          stall_o
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0]   regs_q [DEPTH];
   logic [DATA_W-1:0]   regs_d [DEPTH];
   logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic [DATA_W-1:0]   mv_data, rd;
   logic [2*DATA_W-1:0] hilo_src;
   logic [ADDR_W-1:0]   ra;
   logic                mv_req, mv_go, gpr_we, mv_we;
   mf_sel_e             mf_sel;

   assign mf_sel = mf_sel_e'(mf_sel_i);
   assign mv_req = (mf_sel == MF_LO) || (mf_sel == MF_HI);

   reg_scoreboard #(
      .ADDR_W   (ADDR_W),
      .NREAD    (NREAD),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .raddr_i      (raddr_i),
      .we_i         (we_i),
      .waddr_i      (waddr_i),
      .mv_req_i     (mv_req),
      .mf_addr_i    (mf_addr_i),
      .issue_i      (issue_i),
      .issue_addr_i (issue_addr_i),
      .issue_hilo_i (issue_hilo_i),
      .hilo_we_i    (hilo_we_i),
      .stall_o      (stall_o),
      .mv_go_o      (mv_go)
   );

   always_comb begin
      // A move in the same cycle as a HI/LO load forwards the incoming half
      hilo_src = hilo_we_i ? hilo_wdata_i : {hi_q, lo_q};
      mv_data  = (mf_sel == MF_HI) ? hilo_src[2*DATA_W-1:DATA_W] : hilo_src[DATA_W-1:0];

      gpr_we = we_i && !((ZERO_REG != 0) && (waddr_i == '0));
      mv_we  = mv_go && !((ZERO_REG != 0) && (mf_addr_i == '0));

      regs_d = regs_q;
      if (mv_we)  regs_d[mf_addr_i] = mv_data;
      if (gpr_we) regs_d[waddr_i]   = wdata_i;

      hi_d = hilo_we_i ? hilo_wdata_i[2*DATA_W-1:DATA_W] : hi_q;
      lo_d = hilo_we_i ? hilo_wdata_i[DATA_W-1:0]        : lo_q;
   end

   always_comb begin
      rdata_o = '0;
      rd      = '0;
      ra      = '0;
      for (int unsigned k = 0; k < NREAD; k++) begin
         ra = raddr_i[k*ADDR_W +: ADDR_W];
         rd = regs_q[ra];
         if (mv_we && (mf_addr_i == ra)) rd = mv_data;
         if (gpr_we && (waddr_i == ra))  rd = wdata_i;
         if ((ZERO_REG != 0) && (ra == '0)) rd = '0;
         rdata_o[k*DATA_W +: DATA_W] = rd;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         regs_q <= '{default: '0};
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         regs_q <= regs_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
      end
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed and random checks of reg_file_sb against a behavioural register/scoreboard model.
module tb_reg_file_sb;

   logic        clk;
   logic        rst_i;
   logic [9:0]  raddr_i;
   logic [63:0] rdata_o;
   logic        we_i;
   logic [4:0]  waddr_i;
   logic [31:0] wdata_i;
   logic        hilo_we_i;
   logic [63:0] hilo_wdata_i;
   logic [1:0]  mf_sel_i;
   logic [4:0]  mf_addr_i;
   logic        issue_i;
   logic [4:0]  issue_addr_i;
   logic        issue_hilo_i;
   logic [2:0]  stall_o;

   int unsigned total = 0;
   int unsigned bad   = 0;

   logic [31:0] m_gpr [32];
   logic        m_pend [32];
   logic [31:0] m_hi, m_lo;
   logic        m_hpend;

   reg_file_sb #(
      .DATA_W   (32),
      .ADDR_W   (5),
      .NREAD    (2),
      .ZERO_REG (1)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .raddr_i      (raddr_i),
      .rdata_o      (rdata_o),
      .we_i         (we_i),
      .waddr_i      (waddr_i),
      .wdata_i      (wdata_i),
      .hilo_we_i    (hilo_we_i),
      .hilo_wdata_i (hilo_wdata_i),
      .mf_sel_i     (mf_sel_i),
      .mf_addr_i    (mf_addr_i),
      .issue_i      (issue_i),
      .issue_addr_i (issue_addr_i),
      .issue_hilo_i (issue_hilo_i),
      .stall_o      (stall_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rd(input int k);
      return rdata_o[k*32 +: 32];
   endfunction

   // Reference rules written directly from the register-file behaviour
   function automatic logic mv_valid();
      return (mf_sel_i == 2'b01) || (mf_sel_i == 2'b10);
   endfunction

   function automatic logic mv_blocked();
      return mv_valid() && m_hpend && !hilo_we_i;
   endfunction

   function automatic logic mv_ok();
      return mv_valid() && !mv_blocked();
   endfunction

   function automatic logic [31:0] mv_val();
      logic [31:0] hi, lo;
      hi = hilo_we_i ? hilo_wdata_i[63:32] : m_hi;
      lo = hilo_we_i ? hilo_wdata_i[31:0]  : m_lo;
      return (mf_sel_i == 2'b10) ? hi : lo;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (we_i && waddr_i == a) return wdata_i;
      if (mv_ok() && mf_addr_i == a) return mv_val();
      return m_gpr[a];
   endfunction

   function automatic logic exp_stall(input logic [4:0] a);
      if (a == 5'd0) return 1'b0;
      if (we_i && waddr_i == a) return 1'b0;
      if (mv_ok() && mf_addr_i == a) return 1'b0;
      return m_pend[a];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         m_gpr[i]  = 32'd0;
         m_pend[i] = 1'b0;
      end
      m_hi = 32'd0;
      m_lo = 32'd0;
      m_hpend = 1'b0;
   endtask

   task automatic model_check();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("m_rd%0d", k), {32'd0, rd(k)}, {32'd0, exp_rd(raddr_i[k*5 +: 5])});
         chk($sformatf("m_st%0d", k), {63'd0, stall_o[k]}, {63'd0, exp_stall(raddr_i[k*5 +: 5])});
      end
      chk("m_stmv", {63'd0, stall_o[2]}, {63'd0, mv_blocked()});
   endtask

   task automatic model_update();
      logic        ok;
      logic [31:0] d;
      ok = mv_ok();
      d  = mv_val();
      if (ok) begin
         if (mf_addr_i != 5'd0) m_gpr[mf_addr_i] = d;
         m_pend[mf_addr_i] = 1'b0;
      end
      if (we_i) begin
         if (waddr_i != 5'd0) m_gpr[waddr_i] = wdata_i;
         m_pend[waddr_i] = 1'b0;
      end
      if (issue_i && issue_addr_i != 5'd0) m_pend[issue_addr_i] = 1'b1;
      if (hilo_we_i) begin
         m_hi = hilo_wdata_i[63:32];
         m_lo = hilo_wdata_i[31:0];
      end
      if (issue_hilo_i) m_hpend = 1'b1;
      else if (hilo_we_i) m_hpend = 1'b0;
   endtask

   task automatic idle();
      raddr_i = '0; we_i = 0; waddr_i = '0; wdata_i = '0;
      hilo_we_i = 0; hilo_wdata_i = '0; mf_sel_i = 2'b00; mf_addr_i = '0;
      issue_i = 0; issue_addr_i = '0; issue_hilo_i = 0;
   endtask

   task automatic cycle();
      model_check();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic async_reset();
      #2;
      rst_i = 1'b0;
      #1;
      model_clear();
      chk("ar_rd0", {32'd0, rd(0)}, 64'd0);
      chk("ar_st", {61'd0, stall_o}, 64'd0);
      model_check();
      @(posedge clk);
      @(negedge clk);
      rst_i = 1'b1;
   endtask

   initial begin
      rst_i = 1'b0;
      idle();
      model_clear();
      #3;
      chk("rst_rd0", {32'd0, rd(0)}, 64'd0);
      chk("rst_st", {61'd0, stall_o}, 64'd0);
      @(negedge clk);
      rst_i = 1'b1;

      idle(); raddr_i[4:0] = 5'd5; #1;
      chk("r5_init", {32'd0, rd(0)}, 64'd0);
      chk("r5_st", {61'd0, stall_o}, 64'd0);
      cycle();

      idle(); raddr_i[4:0] = 5'd5; we_i = 1; waddr_i = 5'd5; wdata_i = 32'h1234; #1;
      chk("byp_r5", {32'd0, rd(0)}, 64'h1234);
      cycle();
      idle(); raddr_i[4:0] = 5'd5; #1;
      chk("hold_r5", {32'd0, rd(0)}, 64'h1234);
      cycle();

      idle(); raddr_i[4:0] = 5'd0; we_i = 1; waddr_i = 5'd0; wdata_i = 32'hFFFF; #1;
      chk("r0_wr", {32'd0, rd(0)}, 64'd0);
      cycle();
      idle(); issue_i = 1; issue_addr_i = 5'd0; #1; cycle();
      idle(); raddr_i[4:0] = 5'd0; #1;
      chk("r0_rd", {32'd0, rd(0)}, 64'd0);
      chk("r0_st", {61'd0, stall_o}, 64'd0);
      cycle();

      idle(); issue_i = 1; issue_addr_i = 5'd7; #1; cycle();
      idle(); raddr_i[4:0] = 5'd7; #1;
      chk("r7_st", {63'd0, stall_o[0]}, 64'd1);
      cycle();
      idle(); raddr_i[4:0] = 5'd7; we_i = 1; waddr_i = 5'd7; wdata_i = 32'h55; #1;
      chk("r7_wst", {63'd0, stall_o[0]}, 64'd0);
      chk("r7_wrd", {32'd0, rd(0)}, 64'h55);
      cycle();
      idle(); raddr_i[4:0] = 5'd7; #1;
      chk("r7_clr", {63'd0, stall_o[0]}, 64'd0);
      cycle();

      idle(); issue_hilo_i = 1; #1; cycle();
      idle(); mf_sel_i = 2'b01; mf_addr_i = 5'd3; raddr_i[9:5] = 5'd3; #1;
      chk("mv_st", {63'd0, stall_o[2]}, 64'd1);
      chk("mv_r3", {32'd0, rd(1)}, 64'd0);
      cycle();
      idle(); mf_sel_i = 2'b01; mf_addr_i = 5'd3; raddr_i[9:5] = 5'd3;
      hilo_we_i = 1; hilo_wdata_i = 64'h00000002_00000009; #1;
      chk("mvw_st", {63'd0, stall_o[2]}, 64'd0);
      chk("mvw_r3", {32'd0, rd(1)}, 64'd9);
      cycle();
      idle(); mf_sel_i = 2'b10; mf_addr_i = 5'd6; raddr_i[4:0] = 5'd6; #1;
      chk("mvhi_r6", {32'd0, rd(0)}, 64'd2);
      cycle();
      idle(); raddr_i = {5'd6, 5'd3}; #1;
      chk("hold_r3", {32'd0, rd(0)}, 64'd9);
      chk("hold_r6", {32'd0, rd(1)}, 64'd2);
      cycle();

      idle(); we_i = 1; waddr_i = 5'd4; wdata_i = 32'hA; mf_sel_i = 2'b10; mf_addr_i = 5'd4;
      issue_i = 1; issue_addr_i = 5'd4; raddr_i[4:0] = 5'd4; #1;
      chk("col_byp", {32'd0, rd(0)}, 64'hA);
      cycle();
      idle(); raddr_i[4:0] = 5'd4; #1;
      chk("col_r4", {32'd0, rd(0)}, 64'hA);
      chk("col_pend", {63'd0, stall_o[0]}, 64'd1);
      cycle();
      idle(); issue_hilo_i = 1; #1; cycle();
      idle(); raddr_i[4:0] = 5'd4; mf_sel_i = 2'b01; mf_addr_i = 5'd3; #1;
      chk("both_st", {61'd0, stall_o}, 64'b101);
      model_check();
      idle(); raddr_i = {5'd3, 5'd4};
      async_reset();
      idle(); raddr_i = {5'd3, 5'd4}; #1;
      chk("post_r3", {32'd0, rd(1)}, 64'd0);
      chk("post_st", {61'd0, stall_o}, 64'd0);
      cycle();

      for (int i = 0; i < 400; i++) begin
         idle();
         raddr_i      = {2'b00, 3'($urandom_range(0, 7)), 2'b00, 3'($urandom_range(0, 7))};
         we_i         = ($urandom_range(0, 1) == 0);
         waddr_i      = 5'($urandom_range(0, 7));
         wdata_i      = $urandom;
         hilo_we_i    = ($urandom_range(0, 4) == 0);
         hilo_wdata_i = {$urandom, $urandom};
         mf_sel_i     = 2'($urandom_range(0, 3));
         mf_addr_i    = 5'($urandom_range(0, 7));
         issue_i      = ($urandom_range(0, 2) == 0);
         issue_addr_i = 5'($urandom_range(0, 7));
         issue_hilo_i = ($urandom_range(0, 5) == 0);
         #1;
         if (i == 200) begin
            idle();
            raddr_i = {5'd2, 5'd1};
            async_reset();
         end else begin
            cycle();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1);
   end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NREAD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1, 1 = register 0 reads 0 and ignores writes.
REQ-005 SHALL have ports clk_i in 1 (clock) and rst_i in 1 (reset); one clock; reset is asynchronous, active-low.
REQ-006 SHALL have port raddr_i in NREAD*ADDR_W, packed read addresses, port k at [k*ADDR_W +: ADDR_W].
REQ-007 SHALL have port rdata_o out NREAD*DATA_W, packed read data.
REQ-008 SHALL have ports we_i in 1, waddr_i in ADDR_W, wdata_i in DATA_W: GPR write port.
REQ-009 SHALL have ports hilo_we_i in 1, hilo_wdata_i in 2*DATA_W: HI = upper half, LO = lower half.
REQ-010 SHALL have ports mf_sel_i in 2 (00 none, 01 LO, 10 HI, 11 reserved = none) and mf_addr_i in ADDR_W: move HI/LO to GPR.
REQ-011 SHALL have ports issue_i in 1, issue_addr_i in ADDR_W: mark GPR pending; issue_hilo_i in 1: mark HI/LO pending.
REQ-012 SHALL have port stall_o out NREAD+1: bit k = read port k hazard, bit NREAD = move hazard.

Function
REQ-013 SHALL write GPR waddr_i with wdata_i on posedge clk_i when we_i=1.
REQ-014 SHALL drive rdata_o combinationally; a read matching a same-cycle write (we_i, or an unstalled move) SHALL return the write data (write-through bypass).
REQ-015 With ZERO_REG=1, reads of address 0 SHALL return 0, writes to 0 SHALL be dropped, and issue to 0 SHALL not set pending.
REQ-016 SHALL load HI and LO from hilo_wdata_i on posedge when hilo_we_i=1.
REQ-017 An unstalled move SHALL write the selected HI/LO to GPR mf_addr_i on posedge; if hilo_we_i is high in the same cycle, the new hilo_wdata_i half SHALL be written.
REQ-018 If we_i and a move target the same address in one cycle, we_i data SHALL win; different addresses SHALL both be written.
REQ-019 Scoreboard: pending[a] SHALL set on posedge when issue_i and issue_addr_i=a, and clear on a GPR write (we_i or move) to a; simultaneous set and clear to the same a SHALL leave it set.
REQ-020 hilo_pend SHALL set on issue_hilo_i and clear on hilo_we_i; if both are high, it SHALL stay set.
REQ-021 stall_o[k] SHALL be 1 when pending[raddr k]=1 and no same-cycle write to that address occurs; it SHALL be 0 for address 0 when ZERO_REG=1.
REQ-022 stall_o[NREAD] SHALL be 1 when mf_sel_i selects HI/LO, hilo_pend=1 and hilo_we_i=0.
REQ-023 A stalled move SHALL perform no write and SHALL not clear pending.

Reset
REQ-024 rst_i=0 SHALL immediately clear all GPRs, HI, LO, all pending bits and hilo_pend, regardless of clock.
REQ-025 After reset, rdata_o SHALL be 0 and stall_o SHALL be 0 until an issue occurs; reset mid-operation SHALL discard all pending state.

Structure
REQ-026 Shared package SHALL hold the mf_sel encodings (MF_NONE, MF_LO, MF_HI) and the default DATA_W/ADDR_W constants.
REQ-027 The scoreboard (pending bits, set/clear, hazard compare) SHALL be sub-module reg_scoreboard; storage and bypass SHALL stay in reg_file_sb.

Verification
REQ-028 Reset; read r5 on port 0 -> rdata 0, stall_o 0.
REQ-029 we_i: r5=0x1234 and read r5 in the same cycle -> rdata 0x1234 (bypass), held afterwards.
REQ-030 Write r0=0xFFFF with ZERO_REG=1 -> r0 reads 0; issue r0 -> no stall.
REQ-031 issue r7, then read r7 -> stall_o[0]=1; on the cycle with we_i r7=0x55 -> stall 0, data 0x55.
REQ-032 issue_hilo, then mf_sel=LO to r3 -> stall_o[NREAD]=1, r3 unchanged; hilo_we_i 0x00000002_00000009 with move -> r3=9, HI=2.
REQ-033 Same cycle: we_i r4=0xA, move HI->r4, issue r4 -> r4=0xA, pending[r4] stays 1; async reset mid-stall -> all cleared.
